// File: rtl/mem_wb_stage_if.sv
// Memory-to-writeback bus: Memory-stage instruction fields in, writeback results and stall out.
interface mem_wb_stage_if;
    logic        valid_m;
    logic        flush_m;
    logic        RegWriteM;
    logic [1:0]  ResultSrcM;
    logic        is_load_m;
    logic [2:0]  funct3M;
    logic [31:0] ALUResultM;
    logic [31:0] RdataM;
    logic        dmem_rvalid;
    logic [4:0]  RdM;
    logic [31:0] PCPlus4M;

    logic        stall_req;
    logic        validW;
    logic        RegWriteW;
    logic [4:0]  RdW;
    logic [31:0] ResultW;
    logic        misalign_err;
    logic        timeout_err;

    modport master (
        output valid_m, flush_m, RegWriteM, ResultSrcM, is_load_m, funct3M,
               ALUResultM, RdataM, dmem_rvalid, RdM, PCPlus4M,
        input  stall_req, validW, RegWriteW, RdW, ResultW, misalign_err, timeout_err
    );

    modport slave (
        input  valid_m, flush_m, RegWriteM, ResultSrcM, is_load_m, funct3M,
               ALUResultM, RdataM, dmem_rvalid, RdM, PCPlus4M,
        output stall_req, validW, RegWriteW, RdW, ResultW, misalign_err, timeout_err
    );
endinterface

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register with load-response wait, load data extraction,
// misalignment detection and a watchdog that abandons loads whose response never arrives.
module mem_wb_stage #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input logic            clk,
    input logic            rst_n,
    mem_wb_stage_if.slave  bus
);

    typedef enum logic {IDLE, WAIT} state_t;

    localparam logic [9:0] LAST_WAIT = 10'(TIMEOUT_CYCLES - 1);

    state_t      state, next_state;
    logic [9:0]  wait_cnt;
    logic        capture;
    logic        expire;
    logic        stall;
    logic        misaligned;
    logic [31:0] load_data;
    logic [31:0] result;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= next_state;
    end

    // The counter sits at zero in IDLE, so every entry into WAIT starts a fresh count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            wait_cnt <= '0;
        else if (state == IDLE)
            wait_cnt <= '0;
        else
            wait_cnt <= wait_cnt + 10'd1;
    end

    always_comb begin
        next_state = state;
        capture    = 1'b0;
        expire     = 1'b0;
        stall      = 1'b0;
        case (state)
            IDLE: begin
                if (bus.valid_m && !bus.flush_m) begin
                    if (!bus.is_load_m || bus.dmem_rvalid) begin
                        capture = 1'b1;
                    end else begin
                        stall      = 1'b1;
                        next_state = WAIT;
                    end
                end
            end
            WAIT: begin
                // A response arriving in the expiry cycle wins over the watchdog.
                if (bus.dmem_rvalid) begin
                    capture    = 1'b1;
                    next_state = IDLE;
                end else if (wait_cnt == LAST_WAIT) begin
                    expire     = 1'b1;
                    next_state = IDLE;
                end else begin
                    stall = 1'b1;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    assign bus.stall_req = rst_n & stall;

    always_comb begin
        misaligned = 1'b0;
        if (bus.is_load_m) begin
            case (bus.funct3M)
                3'b000, 3'b100: misaligned = 1'b0;
                3'b001, 3'b101: misaligned = bus.ALUResultM[0];
                default:        misaligned = (bus.ALUResultM[1:0] != 2'b00);
            endcase
        end
    end

    always_comb begin
        logic [7:0]  lane_byte;
        logic [15:0] lane_half;
        case (bus.ALUResultM[1:0])
            2'b00:   lane_byte = bus.RdataM[7:0];
            2'b01:   lane_byte = bus.RdataM[15:8];
            2'b10:   lane_byte = bus.RdataM[23:16];
            default: lane_byte = bus.RdataM[31:24];
        endcase
        lane_half = bus.ALUResultM[1] ? bus.RdataM[31:16] : bus.RdataM[15:0];
        case (bus.funct3M)
            3'b000:  load_data = {{24{lane_byte[7]}}, lane_byte};
            3'b001:  load_data = {{16{lane_half[15]}}, lane_half};
            3'b100:  load_data = {24'd0, lane_byte};
            3'b101:  load_data = {16'd0, lane_half};
            default: load_data = bus.RdataM;
        endcase
    end

    always_comb begin
        case (bus.ResultSrcM)
            2'b01:   result = load_data;
            2'b10:   result = bus.PCPlus4M;
            default: result = bus.ALUResultM;
        endcase
    end

    // A timed-out load still retires so the pipeline sees it leave, but never writes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.validW       <= 1'b0;
            bus.RegWriteW    <= 1'b0;
            bus.RdW          <= '0;
            bus.ResultW      <= '0;
            bus.misalign_err <= 1'b0;
            bus.timeout_err  <= 1'b0;
        end else begin
            bus.validW       <= capture | expire;
            bus.RegWriteW    <= capture & bus.RegWriteM & (bus.RdM != 5'd0) & ~misaligned;
            bus.misalign_err <= capture & misaligned;
            bus.timeout_err  <= bus.timeout_err | expire;
            if (capture || expire)
                bus.RdW <= bus.RdM;
            if (capture)
                bus.ResultW <= result;
        end
    end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Scoreboard bench for mem_wb_stage: expected retirements are queued at accept time
// and matched against validW pulses, including their cycle of arrival.
module tb_mem_wb_stage;

    typedef struct {
        int          cyc;
        logic [4:0]  rd;
        logic [31:0] res;
        logic        rw;
        logic        mis;
        logic        chk_res;
    } exp_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    int   cyc;
    exp_t sb[$];

    mem_wb_stage_if bus();

    mem_wb_stage #(.TIMEOUT_CYCLES(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] expResult(input logic [1:0] src, input logic [2:0] f3,
                                              input logic [31:0] a, input logic [31:0] d,
                                              input logic [31:0] pc);
        logic [31:0] sb_word;
        logic [31:0] sh_word;
        if (src == 2'b10) return pc;
        if (src != 2'b01) return a;
        sb_word = d >> (8 * a[1:0]);
        sh_word = d >> (a[1] ? 16 : 0);
        case (f3)
            3'b000:  return 32'($signed(sb_word[7:0]));
            3'b100:  return sb_word & 32'h0000_00FF;
            3'b001:  return 32'($signed(sh_word[15:0]));
            3'b101:  return sh_word & 32'h0000_FFFF;
            default: return d;
        endcase
    endfunction

    function automatic logic expMis(input logic load, input logic [2:0] f3, input logic [31:0] a);
        if (!load) return 1'b0;
        if (f3 == 3'b000 || f3 == 3'b100) return 1'b0;
        if (f3 == 3'b001 || f3 == 3'b101) return a[0];
        return a[1:0] != 2'b00;
    endfunction

    task automatic applyStimulus(input logic valid, input logic load, input logic [2:0] f3,
                                 input logic [1:0] src, input logic [31:0] alu,
                                 input logic [31:0] rdata, input logic rvalid,
                                 input logic [4:0] rd, input logic rw);
        bus.valid_m     = valid;
        bus.flush_m     = 1'b0;
        bus.is_load_m   = load;
        bus.funct3M     = f3;
        bus.ResultSrcM  = src;
        bus.ALUResultM  = alu;
        bus.RdataM      = rdata;
        bus.dmem_rvalid = rvalid;
        bus.RdM         = rd;
        bus.RegWriteM   = rw;
    endtask

    task automatic pushExp(input logic [4:0] rd, input logic [31:0] res, input logic rw,
                           input logic mis, input logic chk);
        exp_t e;
        e.cyc = cyc + 1; e.rd = rd; e.res = res; e.rw = rw; e.mis = mis; e.chk_res = chk;
        sb.push_back(e);
    endtask

    // Drives one instruction that is accepted on the coming edge and queues its retirement.
    task automatic doAccept(input logic load, input logic [2:0] f3, input logic [1:0] src,
                            input logic [31:0] alu, input logic [31:0] rdata,
                            input logic [4:0] rd, input logic rw);
        logic mis;
        applyStimulus(1'b1, load, f3, src, alu, rdata, 1'b1, rd, rw);
        mis = expMis(load, f3, alu);
        pushExp(rd, expResult(src, f3, alu, rdata, bus.PCPlus4M), rw && rd != 5'd0 && !mis, mis, 1'b1);
        #1 checkOutput("stall_on_accept", 32'(bus.stall_req), 32'd0);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        applyStimulus(1'b0, 1'b0, 3'b010, 2'b00, 32'd0, 32'd0, 1'b0, 5'd0, 1'b0);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        exp_t e;
        cyc = 0;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (bus.validW) begin
                if (sb.size() == 0) begin
                    checkOutput("spurious_validW", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    checkOutput("latency", 32'(cyc), 32'(e.cyc));
                    checkOutput("RegWriteW", 32'(bus.RegWriteW), 32'(e.rw));
                    checkOutput("RdW", 32'(bus.RdW), 32'(e.rd));
                    checkOutput("misalign_err", 32'(bus.misalign_err), 32'(e.mis));
                    if (e.chk_res) checkOutput("ResultW", bus.ResultW, e.res);
                end
            end else begin
                checkOutput("RegWriteW_idle", 32'(bus.RegWriteW), 32'd0);
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog simulation did not complete");
        $fatal(1, "[TB] time limit");
    end

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        bus.PCPlus4M = 32'h0000_0100;
        idle(0);
        repeat (3) @(negedge clk);
        checkOutput("rst_outputs",
                    {25'd0, bus.validW, bus.RegWriteW, bus.misalign_err, bus.timeout_err, bus.stall_req, 2'b00}, 32'd0);
        checkOutput("rst_RdW", 32'(bus.RdW), 32'd0);
        checkOutput("rst_ResultW", bus.ResultW, 32'd0);

        rst_n = 1'b1;
        doAccept(1'b0, 3'b010, 2'b00, 32'h0000_1234, 32'd0, 5'd5, 1'b1);
        doAccept(1'b0, 3'b010, 2'b10, 32'h0000_5555, 32'd0, 5'd7, 1'b1);
        doAccept(1'b0, 3'b010, 2'b11, 32'hCAFE_0001, 32'd0, 5'd8, 1'b1);
        doAccept(1'b1, 3'b000, 2'b01, 32'h0000_1003, 32'h80FF_FF7F, 5'd10, 1'b1);
        doAccept(1'b1, 3'b100, 2'b01, 32'h0000_1003, 32'h80FF_FF7F, 5'd11, 1'b1);
        doAccept(1'b1, 3'b000, 2'b01, 32'h0000_1001, 32'h1234_F600, 5'd12, 1'b1);
        doAccept(1'b1, 3'b001, 2'b01, 32'h0000_2002, 32'h8001_1234, 5'd13, 1'b1);
        doAccept(1'b1, 3'b101, 2'b01, 32'h0000_2002, 32'h8001_1234, 5'd14, 1'b1);
        doAccept(1'b1, 3'b001, 2'b01, 32'h0000_2000, 32'h0000_9ABC, 5'd15, 1'b1);
        doAccept(1'b1, 3'b011, 2'b01, 32'h0000_3000, 32'hDEAD_BEEF, 5'd16, 1'b1);
        doAccept(1'b0, 3'b010, 2'b00, 32'h0000_0042, 32'd0, 5'd0, 1'b1);
        doAccept(1'b1, 3'b010, 2'b01, 32'h0000_4002, 32'h1111_2222, 5'd17, 1'b1);
        doAccept(1'b1, 3'b101, 2'b01, 32'h0000_4001, 32'h1111_2222, 5'd18, 1'b1);

        // Flushed instruction and a stray response while idle must not retire.
        applyStimulus(1'b1, 1'b0, 3'b010, 2'b00, 32'h0000_0099, 32'd0, 1'b0, 5'd3, 1'b1);
        bus.flush_m = 1'b1;
        @(negedge clk);
        applyStimulus(1'b0, 1'b1, 3'b010, 2'b01, 32'd0, 32'hFFFF_FFFF, 1'b1, 5'd4, 1'b1);
        @(negedge clk);

        // Load whose response arrives three cycles late; a flush in WAIT is ignored.
        applyStimulus(1'b1, 1'b1, 3'b010, 2'b01, 32'h0000_5000, 32'h0BAD_F00D, 1'b0, 5'd20, 1'b1);
        for (int i = 0; i < 3; i++) begin
            bus.flush_m = (i == 2);
            #1 checkOutput("stall_wait", 32'(bus.stall_req), 32'd1);
            @(negedge clk);
        end
        bus.flush_m = 1'b0;
        bus.dmem_rvalid = 1'b1;
        pushExp(5'd20, 32'h0BAD_F00D, 1'b1, 1'b0, 1'b1);
        #1 checkOutput("stall_resp", 32'(bus.stall_req), 32'd0);
        @(negedge clk);
        idle(1);

        // Watchdog expiry after four WAIT cycles.
        checkOutput("timeout_before", 32'(bus.timeout_err), 32'd0);
        applyStimulus(1'b1, 1'b1, 3'b010, 2'b01, 32'h0000_6000, 32'd0, 1'b0, 5'd9, 1'b1);
        for (int i = 0; i < 4; i++) begin
            #1 checkOutput("stall_to", 32'(bus.stall_req), 32'd1);
            @(negedge clk);
        end
        pushExp(5'd9, 32'd0, 1'b0, 1'b0, 1'b0);
        #1 checkOutput("stall_expire", 32'(bus.stall_req), 32'd0);
        @(negedge clk);
        idle(1);
        checkOutput("timeout_set", 32'(bus.timeout_err), 32'd1);
        idle(3);
        checkOutput("timeout_sticky", 32'(bus.timeout_err), 32'd1);

        // Response in the expiry cycle is a normal capture.
        applyStimulus(1'b1, 1'b1, 3'b100, 2'b01, 32'h0000_7002, 32'h00AB_0000, 1'b0, 5'd21, 1'b1);
        repeat (4) @(negedge clk);
        bus.dmem_rvalid = 1'b1;
        pushExp(5'd21, 32'h0000_00AB, 1'b1, 1'b0, 1'b1);
        #1 checkOutput("stall_late_resp", 32'(bus.stall_req), 32'd0);
        @(negedge clk);
        idle(2);

        // Reset asserted in WAIT abandons the load; capture resumes on the first edge after release.
        applyStimulus(1'b1, 1'b1, 3'b010, 2'b01, 32'h0000_8000, 32'h7777_7777, 1'b0, 5'd22, 1'b1);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("async_rst_outputs",
                    {26'd0, bus.validW, bus.RegWriteW, bus.misalign_err, bus.timeout_err, bus.stall_req, 1'b0}, 32'd0);
        checkOutput("async_rst_data", {bus.ResultW[26:0], bus.RdW}, 32'd0);
        idle(1);
        idle(1);
        rst_n = 1'b1;
        doAccept(1'b0, 3'b010, 2'b00, 32'h0000_ABCD, 32'd0, 5'd23, 1'b1);
        idle(4);
        checkOutput("timeout_cleared", 32'(bus.timeout_err), 32'd0);
        checkOutput("sb_empty", 32'(sb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
